multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Sequencer for the RV32I multi-cycle core. Fetches an instruction over a req/ack bus and holds it in the IR.
//  The IR feeds immgen, the regfile and the ALU. Steps the datapath through FETCH/DECODE/EXEC/MEM/WB and pulses PC/RF write enables.
// PARAMETERS
//  MAX_WAIT  16  cycles a req may stay unacknowledged before a bus-timeout trap (>=1)
//  RESET_PC  32'h0000_0000  value presented on o_pc_rst_val for the PC register
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst_n       in   1   asynchronous reset, active low
//  o_imem_req    out  1   instruction fetch request
//  i_imem_ack    in   1   fetch acknowledge; i_imem_rdata valid in the same cycle
//  i_imem_rdata  in   32  fetched instruction
//  o_dmem_req    out  1   data access request (load/store)
//  o_dmem_we     out  1   1=store, 0=load; valid while o_dmem_req
//  i_dmem_ack    in   1   data access acknowledge
//  i_br_taken    in   1   branch comparator result, sampled in EXEC
//  o_instr       out  32  IR contents (to immgen, regfile addresses, ALU decode)
//  o_opa_sel     out  1   0=rs1, 1=PC
//  o_opb_sel     out  1   0=rs2, 1=imm
//  o_wb_sel      out  2   0=ALU, 1=mem, 2=PC+4, 3=imm (LUI)
//  o_pc_sel      out  2   0=PC+4, 1=PC+imm (branch/JAL), 2=ALU&~1 (JALR)
//  o_pc_we       out  1   one-cycle PC update pulse
//  o_rf_we       out  1   one-cycle regfile write pulse
//  o_pc_rst_val  out  32  constant RESET_PC
//  o_busy        out  1   high in every state except TRAP
//  o_trap        out  1   sticky trap flag
//  o_trap_cause  out  2   0=none, 1=bus timeout, 2=illegal opcode
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=FETCH; IR=32'h0000_0013 (NOP); wait cnt=0.
//   All req/we/pulse outputs=0; selects=0; o_trap=0, cause=0; o_busy=1. Effective immediately, mid-transfer included.
//  FETCH: o_imem_req=1 until ack. On ack, IR<=i_imem_rdata -> DECODE. An ack without a req is ignored.
//  DECODE: 1 cycle. Classify opcode[6:0]; selects driven from the class from here through WB.
//  EXEC: 1 cycle. Load/store -> MEM. All other classes -> WB. i_br_taken is registered here.
//  MEM: o_dmem_req=1, o_dmem_we=store, held until i_dmem_ack -> WB.
//  WB: o_pc_we=1 always. o_rf_we=1 for LOAD, OP-IMM, OP, LUI, AUIPC, JAL, JALR; 0 for STORE, BRANCH. Then -> FETCH.
//   The write is suppressed when IR[11:7]=0 (x0).
//  Branch: pc_sel=1 if taken, else 0. JAL: pc_sel=1, wb_sel=2. JALR: pc_sel=2, wb_sel=2.
//  Latency with zero-wait acks (req and ack in the same cycle): ALU/branch/jump 4 cycles; load/store 5 cycles.
//  Timeout: the wait counter counts cycles with req=1 and ack=0 and clears on ack/state exit.
//   When the counter reaches MAX_WAIT: TRAP, cause=1, req drops the next cycle.
//   An ack in the same cycle the limit is reached wins (no trap).
//  TRAP: terminal. All req/we=0; o_busy=0; o_trap=1; IR frozen. Exit only via reset.
//  o_pc_we and o_rf_we are never high outside WB. The two reqs are never high together.
// CONFIGURATION
//  MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined: an opcode outside the RV32I set, or IR[1:0]!=2'b11,
//   goes DECODE->TRAP with cause=2 and no pc_we.
//  Not defined: the same opcodes execute as NOP (DECODE->EXEC->WB, pc_sel=0, rf_we=0). Cause 2 never occurs.
// STRUCTURE
//  riscv_pkg: opcode localparams (OP_LOAD 7'b0000011, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
//   OP_JAL, OP_JALR, OP_OP), state enum ctrl_state_e, pc_sel_e, wb_sel_e, trap_cause_e, NOP_INSTR.
//  Sub-module opcode_class_dec: combinational, IR -> one-hot class + legal flag.
//  This module holds the FSM, IR, wait counter and registered selects.
// TESTING
//  ADDI x1,x0,5 (32'h00500093), zero-wait ack -> rf_we pulse in cycle 4, pc_sel=0, wb_sel=0, opb_sel=1.
//  LW with dmem ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, wb_sel=1, rf_we 1 cycle later.
//  BEQ with i_br_taken=1 -> pc_sel=1, rf_we=0, pc_we=1. Repeat with taken=0 -> pc_sel=0.
//  MAX_WAIT=4, imem never acks -> trap after 4 req cycles, cause=1, busy=0. Ack exactly on cycle 4 -> no trap.
//  IR=32'h0000_007F: with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN -> trap, cause=2, no pc_we; without -> NOP, pc_we once.
//  Reset asserted during MEM with dmem_req=1 -> req drops asynchronously; after release FETCH resumes, IR=NOP.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, controller state/select types and class helpers
// for the multi-cycle sequencer (multicycle_ctrl and opcode_class_dec).
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned CLS_LOAD   = 0;
  localparam int unsigned CLS_IMM    = 1;
  localparam int unsigned CLS_STORE  = 2;
  localparam int unsigned CLS_BRANCH = 3;
  localparam int unsigned CLS_LUI    = 4;
  localparam int unsigned CLS_AUIPC  = 5;
  localparam int unsigned CLS_JAL    = 6;
  localparam int unsigned CLS_JALR   = 7;
  localparam int unsigned CLS_OP     = 8;
  localparam int unsigned N_CLS      = 9;

  typedef logic [N_CLS-1:0] cls_vec_t;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0, PC_TARGET = 2'd1, PC_JALR = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'd0, TRAP_BUS = 2'd1, TRAP_ILLEGAL = 2'd2
  } trap_cause_e;

  typedef struct packed {
    logic    opa_sel;
    logic    opb_sel;
    wb_sel_e wb_sel;
    pc_sel_e pc_sel;
  } sel_t;

  function automatic logic [6:0] cls_opcode(input int unsigned idx);
    case (idx)
      CLS_LOAD:   return OP_LOAD;
      CLS_IMM:    return OP_IMM;
      CLS_STORE:  return OP_STORE;
      CLS_BRANCH: return OP_BRANCH;
      CLS_LUI:    return OP_LUI;
      CLS_AUIPC:  return OP_AUIPC;
      CLS_JAL:    return OP_JAL;
      CLS_JALR:   return OP_JALR;
      CLS_OP:     return OP_OP;
      default:    return 7'h00;
    endcase
  endfunction

  // Branch pc_sel starts at PC+4 and is resolved later from the comparator.
  function automatic sel_t class_sel(input cls_vec_t c);
    sel_t s;
    s = '0;
    case (1'b1)
      c[CLS_LOAD]:  begin s.opb_sel = 1'b1; s.wb_sel = WB_MEM; end
      c[CLS_STORE]: s.opb_sel = 1'b1;
      c[CLS_IMM]:   s.opb_sel = 1'b1;
      c[CLS_LUI]:   begin s.opb_sel = 1'b1; s.wb_sel = WB_IMM; end
      c[CLS_AUIPC]: begin s.opa_sel = 1'b1; s.opb_sel = 1'b1; end
      c[CLS_JAL]:   begin s.opa_sel = 1'b1; s.opb_sel = 1'b1; s.wb_sel = WB_PC4; s.pc_sel = PC_TARGET; end
      c[CLS_JALR]:  begin s.opb_sel = 1'b1; s.wb_sel = WB_PC4; s.pc_sel = PC_JALR; end
      c[CLS_OP], c[CLS_BRANCH]: s = '0;
      default:      s = '0;
    endcase
    return s;
  endfunction

  function automatic logic writes_rd(input cls_vec_t c);
    return c[CLS_LOAD] | c[CLS_IMM] | c[CLS_OP] | c[CLS_LUI] |
           c[CLS_AUIPC] | c[CLS_JAL] | c[CLS_JALR];
  endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: 7-bit opcode -> one-hot RV32I class plus legal flag.
// Every RV32I opcode ends in 2'b11, so a bad IR[1:0] simply matches no class.
module opcode_class_dec
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_vec_t   o_cls,
  output logic       o_legal
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CLS; gi++) begin : g_cls
      assign o_cls[gi] = (i_opcode == cls_opcode(gi));
    end
  endgenerate

  assign o_legal = |o_cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB FSM, IR, bus wait-timeout trap.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes (otherwise they run as NOP).
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  input  logic        i_br_taken,
  output logic [31:0] o_instr,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic [1:0]  o_wb_sel,
  output logic [1:0]  o_pc_sel,
  output logic        o_pc_we,
  output logic        o_rf_we,
  output logic [31:0] o_pc_rst_val,
  output logic        o_busy,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  ctrl_state_e      r_state, w_state_next;
  logic [31:0]      r_ir, w_ir_next;
  sel_t             r_sel, w_sel_next;
  trap_cause_e      r_cause, w_cause_next;
  logic [CNT_W-1:0] r_wait_cnt;
  cls_vec_t         w_cls;
  logic             w_legal;
  logic             w_imem_req, w_dmem_req, w_fetch_done, w_ack, w_wait_hit;

  // Requests are gated by reset so they drop the instant reset asserts.
  assign w_imem_req   = i_rst_n & (r_state == ST_FETCH);
  assign w_dmem_req   = i_rst_n & (r_state == ST_MEM);
  assign w_fetch_done = w_imem_req & i_imem_ack;
  assign w_ack        = w_fetch_done | (w_dmem_req & i_dmem_ack);
  assign w_wait_hit   = (w_imem_req | w_dmem_req) & ~w_ack &
                        (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

  // Decoding the next IR lets the selects be registered on the fetch edge; outside FETCH it is the IR.
  assign w_ir_next = w_fetch_done ? i_imem_rdata : r_ir;

  opcode_class_dec u_dec (
    .i_opcode (w_ir_next[6:0]),
    .o_cls    (w_cls),
    .o_legal  (w_legal)
  );

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cause_next = r_cause;
    unique case (r_state)
      ST_FETCH: begin
        if (w_fetch_done) begin
          w_state_next = ST_DECODE;
          w_sel_next   = class_sel(w_cls);
        end else if (w_wait_hit) begin
          w_state_next = ST_TRAP;
          w_cause_next = TRAP_BUS;
        end
      end
      ST_DECODE: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        if (!w_legal) begin
          w_state_next = ST_TRAP;
          w_cause_next = TRAP_ILLEGAL;
        end else begin
          w_state_next = ST_EXEC;
        end
`else
        w_state_next = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        w_state_next = (w_cls[CLS_LOAD] | w_cls[CLS_STORE]) ? ST_MEM : ST_WB;
        if (w_cls[CLS_BRANCH]) begin
          w_sel_next.pc_sel = i_br_taken ? PC_TARGET : PC_PLUS4;
        end
      end
      ST_MEM: begin
        if (w_dmem_req & i_dmem_ack) begin
          w_state_next = ST_WB;
        end else if (w_wait_hit) begin
          w_state_next = ST_TRAP;
          w_cause_next = TRAP_BUS;
        end
      end
      ST_WB: begin
        w_state_next = ST_FETCH;
        w_sel_next   = '0;
      end
      ST_TRAP: w_state_next = ST_TRAP;
      default: w_state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FETCH;
      r_ir       <= NOP_INSTR;
      r_sel      <= '0;
      r_cause    <= TRAP_NONE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_ir    <= w_ir_next;
      r_sel   <= w_sel_next;
      r_cause <= w_cause_next;
      if (w_ack || (w_state_next != r_state)) begin
        r_wait_cnt <= '0;
      end else if (w_imem_req || w_dmem_req) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign o_imem_req   = w_imem_req;
  assign o_dmem_req   = w_dmem_req;
  assign o_dmem_we    = w_dmem_req & w_cls[CLS_STORE];
  assign o_instr      = r_ir;
  assign o_opa_sel    = r_sel.opa_sel;
  assign o_opb_sel    = r_sel.opb_sel;
  assign o_wb_sel     = r_sel.wb_sel;
  assign o_pc_sel     = r_sel.pc_sel;
  assign o_pc_we      = (r_state == ST_WB);
  // Unknown opcodes retire as NOP: no register write, x0 writes dropped.
  assign o_rf_we      = (r_state == ST_WB) & w_legal & writes_rd(w_cls) & (r_ir[11:7] != 5'd0);
  assign o_pc_rst_val = RESET_PC;
  assign o_busy       = (r_state != ST_TRAP);
  assign o_trap       = (r_state == ST_TRAP);
  assign o_trap_cause = r_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction outcome model.
// Honours MULTICYCLE_CTRL_ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_ctrl;

  localparam int          MAXW   = 4;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          NEVER  = 255;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_imem_ack = 1'b0, i_dmem_ack = 1'b0, i_br_taken = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_imem_req, o_dmem_req, o_dmem_we, o_opa_sel, o_opb_sel;
  logic        o_pc_we, o_rf_we, o_busy, o_trap;
  logic [1:0]  o_wb_sel, o_pc_sel, o_trap_cause;
  logic [31:0] o_instr, o_pc_rst_val;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(MAXW), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
    .i_br_taken(i_br_taken), .o_instr(o_instr),
    .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_wb_sel(o_wb_sel), .o_pc_sel(o_pc_sel),
    .o_pc_we(o_pc_we), .o_rf_we(o_rf_we), .o_pc_rst_val(o_pc_rst_val),
    .o_busy(o_busy), .o_trap(o_trap), .o_trap_cause(o_trap_cause)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_ir = NOP;
  logic [6:0]  ops [0:8] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011};

  typedef struct packed {
    logic       legal, mem, store, rf;
    logic       opa, opb, c_opa, c_opb, c_wb;
    logic [1:0] wb, pc;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // What the architecture says each opcode must do; c_* marks selects the spec pins down.
  function automatic exp_t model(input logic [31:0] instr, input logic taken);
    exp_t e;
    logic wr;
    e = '0;
    wr = 1'b0;
    e.legal = 1'b1;
    case (instr[6:0])
      7'b0000011: begin e.mem = 1; e.opb = 1; e.wb = 2'd1; e.c_opa = 1; e.c_opb = 1; e.c_wb = 1; wr = 1; end
      7'b0100011: begin e.mem = 1; e.store = 1; e.opb = 1; e.c_opa = 1; e.c_opb = 1; end
      7'b0010011: begin e.opb = 1; e.c_opa = 1; e.c_opb = 1; e.c_wb = 1; wr = 1; end
      7'b0110011: begin e.c_opa = 1; e.c_opb = 1; e.c_wb = 1; wr = 1; end
      7'b0110111: begin e.wb = 2'd3; e.c_wb = 1; wr = 1; end
      7'b0010111: begin e.opa = 1; e.opb = 1; e.c_opa = 1; e.c_opb = 1; e.c_wb = 1; wr = 1; end
      7'b1101111: begin e.pc = 2'd1; e.wb = 2'd2; e.c_wb = 1; wr = 1; end
      7'b1100111: begin e.pc = 2'd2; e.wb = 2'd2; e.opb = 1; e.c_opa = 1; e.c_opb = 1; e.c_wb = 1; wr = 1; end
      7'b1100011: e.pc = {1'b0, taken};
      default:    e.legal = 1'b0;
    endcase
    e.rf = wr && (instr[11:7] != 5'd0);
    return e;
  endfunction

  task automatic do_reset();
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    i_br_taken = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    check_eq("rst_imem_req", 32'(o_imem_req), 32'd0);
    check_eq("rst_dmem_req", 32'(o_dmem_req), 32'd0);
    check_eq("rst_we", {29'd0, o_dmem_we, o_pc_we, o_rf_we}, 32'd0);
    check_eq("rst_sel", {26'd0, o_opa_sel, o_opb_sel, o_wb_sel, o_pc_sel}, 32'd0);
    check_eq("rst_trap", {29'd0, o_trap, o_trap_cause}, 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd1);
    check_eq("rst_instr", o_instr, NOP);
    check_eq("rst_pc_val", o_pc_rst_val, RST_PC);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    last_ir = NOP;
  endtask

  task automatic run_instr(input logic [31:0] instr, input int id, input int dd, input logic taken);
    exp_t        e;
    logic        imem_to, ill_trap, dmem_to, exp_trap, trapped, done;
    int          cyc, n_ireq, n_dreq, n_dwe, n_pcwe, n_rfwe, n_both, end_cyc, exp_end, exp_d;
    logic [31:0] wb_instr, exp_ir;
    logic [1:0]  wb_pc, wb_wb;
    logic        wb_opa, wb_opb;
    e = model(instr, taken);
    imem_to = (id >= MAXW);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ill_trap = !imem_to && !e.legal;
`else
    ill_trap = 1'b0;
`endif
    dmem_to  = !imem_to && !ill_trap && e.mem && (dd >= MAXW);
    exp_trap = imem_to || ill_trap || dmem_to;
    exp_d    = (!imem_to && e.mem) ? (dmem_to ? MAXW : dd + 1) : 0;
    if (imem_to)       exp_end = MAXW + 1;
    else if (ill_trap) exp_end = id + 3;
    else               exp_end = id + 1 + 2 + exp_d + (dmem_to ? 1 : 1);
    {cyc, n_ireq, n_dreq, n_dwe, n_pcwe, n_rfwe, n_both, end_cyc} = '0;
    {trapped, done, wb_opa, wb_opb, wb_pc, wb_wb} = '0;
    wb_instr = '0;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      i_imem_ack   = 1'b0;
      i_dmem_ack   = 1'b0;
      i_imem_rdata = $urandom;
      i_br_taken   = taken;
      if (o_imem_req && o_dmem_req) n_both++;
      if (o_imem_req) begin
        n_ireq++;
        if (n_ireq > id) begin i_imem_ack = 1'b1; i_imem_rdata = instr; end
      end else if ($urandom_range(0, 3) == 0) begin
        i_imem_ack = 1'b1;
      end
      if (o_dmem_req) begin
        n_dreq++;
        if (o_dmem_we) n_dwe++;
        if (n_dreq > dd) i_dmem_ack = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        i_dmem_ack = 1'b1;
      end
      if (o_rf_we) n_rfwe++;
      if (o_pc_we) begin
        n_pcwe++;
        wb_instr = o_instr; wb_pc = o_pc_sel; wb_wb = o_wb_sel;
        wb_opa = o_opa_sel; wb_opb = o_opb_sel;
        done = 1'b1;
      end
      if (o_trap) begin trapped = 1'b1; done = 1'b1; end
      if (done) end_cyc = cyc;
    end
    $display("[TB] instr=%h imem_wait=%0d dmem_wait=%0d taken=%0b -> cycles=%0d trap=%0b cause=%0d",
             instr, id, dd, taken, end_cyc, trapped, o_trap_cause);
    check_eq("end_cycle", 32'(end_cyc), 32'(exp_end));
    check_eq("trapped", 32'(trapped), 32'(exp_trap));
    check_eq("imem_req_cycles", 32'(n_ireq), 32'(imem_to ? MAXW : id + 1));
    check_eq("dmem_req_cycles", 32'(n_dreq), 32'(exp_d));
    check_eq("dmem_we_cycles", 32'(n_dwe), 32'(e.store ? exp_d : 0));
    check_eq("both_reqs", 32'(n_both), 32'd0);
    check_eq("pc_we_count", 32'(n_pcwe), exp_trap ? 32'd0 : 32'd1);
    check_eq("rf_we_count", 32'(n_rfwe), (!exp_trap && e.rf) ? 32'd1 : 32'd0);
    if (!exp_trap) begin
      check_eq("wb_instr", wb_instr, instr);
      check_eq("pc_sel", 32'(wb_pc), 32'(e.pc));
      if (e.c_wb)  check_eq("wb_sel", 32'(wb_wb), 32'(e.wb));
      if (e.c_opa) check_eq("opa_sel", 32'(wb_opa), 32'(e.opa));
      if (e.c_opb) check_eq("opb_sel", 32'(wb_opb), 32'(e.opb));
      last_ir = instr;
    end else begin
      exp_ir = imem_to ? last_ir : instr;
      check_eq("trap_cause", 32'(o_trap_cause), ill_trap ? 32'd2 : 32'd1);
      check_eq("trap_busy", 32'(o_busy), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("trap_sticky", {28'd0, o_trap, o_busy, o_imem_req, o_dmem_req}, 32'h8);
      check_eq("trap_instr", o_instr, exp_ir);
    end
    if (trapped) do_reset();
  endtask

  initial begin
    do_reset();
    run_instr(32'h0050_0093, 0, 0, 1'b0);      // ADDI x1,x0,5
    run_instr(32'h0000_2103, 0, 3, 1'b0);      // LW x2, dmem late
    run_instr(32'h0000_0463, 0, 0, 1'b1);      // BEQ taken
    run_instr(32'h0000_0463, 1, 0, 1'b0);      // BEQ not taken
    run_instr(32'h0011_2223, 2, 1, 1'b0);      // SW
    run_instr(32'h0080_00EF, 0, 0, 1'b0);      // JAL x1
    run_instr(32'h0000_80E7, 0, 0, 1'b0);      // JALR x1
    run_instr(32'h0000_12B7, 0, 0, 1'b0);      // LUI
    run_instr(32'h0000_1297, 0, 0, 1'b0);      // AUIPC
    run_instr(32'h0020_81B3, 0, 0, 1'b0);      // ADD
    run_instr(32'h0000_0013, 0, 0, 1'b0);      // ADDI x0: write suppressed
    run_instr(32'h0050_0093, MAXW - 1, 0, 1'b0);
    run_instr(32'h0050_0093, NEVER, 0, 1'b0);
    run_instr(32'h0000_2103, 0, NEVER, 1'b0);
    run_instr(32'h0000_007F, 0, 0, 1'b0);
    begin : mid_mem
      int k;
      k = 0;
      while (!o_dmem_req && k < 20) begin
        @(negedge clk);
        k++;
        i_imem_ack   = o_imem_req;
        i_imem_rdata = 32'h0000_2103;
        i_dmem_ack   = 1'b0;
      end
      check_eq("mem_reached", 32'(o_dmem_req), 32'd1);
      do_reset();
      run_instr(32'h0050_0093, 0, 0, 1'b0);
    end
    for (int t = 0; t < 150; t++) begin
      logic [31:0] ins;
      int          kk, id, dd;
      kk  = int'($urandom_range(0, 10));
      ins = $urandom;
      ins[6:0] = (kk < 9) ? ops[kk] : 7'($urandom);
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      id = ($urandom_range(0, 12) == 0) ? NEVER : int'($urandom_range(0, MAXW - 1));
      dd = ($urandom_range(0, 8) == 0) ? NEVER : int'($urandom_range(0, MAXW - 1));
      run_instr(ins, id, dd, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
